// File: rtl/poly_sample_voice_engine.sv
// Polyphonic sample playback engine. One shared sample BRAM (note index in the
// address MSBs) is time-multiplexed across all voices on every sample tick; the
// signed samples are summed, scaled, saturated and emitted once per frame along
// with an offset-binary duty-cycle word for the pwm block.
module poly_sample_voice_engine #(
    parameter int NUM_VOICES   = 4,
    parameter int NUM_NOTES    = 8,
    parameter int NOTE_W       = 3,
    parameter int BRAM_DEPTH   = 8192,
    parameter int ADDR_WIDTH   = 13,
    parameter int SAMPLE_W     = 16,
    parameter int READ_LATENCY = 2,
    parameter int LOOP         = 1,
    parameter int MIX_SHIFT    = 2,
    parameter int DC_W         = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         sample_tick,
    input  logic [NUM_VOICES-1:0]        gate_in,
    input  logic [NUM_VOICES*NOTE_W-1:0] note_in,
    output logic [NOTE_W+ADDR_WIDTH-1:0] mem_addr_out,
    input  logic [SAMPLE_W-1:0]          mem_data_in,
    output logic [SAMPLE_W-1:0]          sample_out,
    output logic                         sample_valid,
    output logic [DC_W-1:0]              dc_out,
    output logic [NUM_VOICES-1:0]        voice_active_out,
    output logic                         busy_out,
    output logic                         overrun_out
);

    localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W   = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam int ACC_W   = SAMPLE_W + ((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SLOT = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(READ_LATENCY);
    localparam logic [VOICE_W-1:0]    LAST_VOICE = VOICE_W'(NUM_VOICES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BRAM_DEPTH - 1);
    localparam logic [NOTE_W:0]       NOTE_LIM   = (NOTE_W + 1)'(NUM_NOTES);
    localparam logic [DC_W-1:0]       DC_RST     = {1'b1, {(DC_W - 1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - SAMPLE_W + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

    logic [1:0]              r_state;
    logic [VOICE_W-1:0]      r_voice;
    logic [CNT_W-1:0]        r_cnt;
    logic [NOTE_W-1:0]       r_note [NUM_VOICES];
    logic [ADDR_WIDTH-1:0]   r_addr [NUM_VOICES];
    logic [NUM_VOICES-1:0]   r_prev_gate;
    logic [NUM_VOICES-1:0]   r_done;
    // r_live: voice reads and advances this frame; r_active: it also contributes
    logic [NUM_VOICES-1:0]   r_live;
    logic [NUM_VOICES-1:0]   r_active;
    logic signed [ACC_W-1:0] r_acc;
    logic [SAMPLE_W-1:0]     r_sample;
    logic                    r_valid;
    logic [DC_W-1:0]         r_dc;
    logic                    r_overrun;

    logic [NOTE_W-1:0]       w_note_in [NUM_VOICES];
    logic [NUM_VOICES-1:0]   w_note_ok;
    logic [NUM_VOICES-1:0]   w_live_next;
    logic signed [ACC_W-1:0] w_data_ext;
    logic signed [ACC_W-1:0] w_addend;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_shift;
    logic [SAMPLE_W-1:0]     w_sat;
    logic [DC_W-1:0]         w_dc;

    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_voice
        assign w_note_in[gv] = note_in[gv*NOTE_W +: NOTE_W];
        assign w_note_ok[gv] = ({1'b0, w_note_in[gv]} < NOTE_LIM);
        // A rising gate re-arms a finished one-shot voice
        assign w_live_next[gv] = gate_in[gv] & (~r_prev_gate[gv] | ~r_done[gv]);
    end

    // Accumulate the current slot's sample, then scale and saturate the running sum
    always_comb begin
        w_data_ext = {{(ACC_W - SAMPLE_W){mem_data_in[SAMPLE_W-1]}}, mem_data_in};
        w_addend   = r_active[r_voice] ? w_data_ext : '0;
        w_acc_next = r_acc + w_addend;
        w_shift    = w_acc_next >>> MIX_SHIFT;
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[SAMPLE_W-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            w_sat = w_shift[SAMPLE_W-1:0];
        end
        // Adding 2^(DC_W-1) modulo 2^DC_W is an MSB flip
        w_dc = {~w_sat[SAMPLE_W-1], w_sat[SAMPLE_W-2 -: DC_W-1]};
    end

    // Shared BRAM address, held for the whole slot; zero when no read is needed
    always_comb begin
        mem_addr_out = '0;
        if (r_state == ST_SLOT && r_active[r_voice]) begin
            mem_addr_out = {r_note[r_voice], r_addr[r_voice]};
        end
    end

    // Frame sequencer, per-voice address/done tracking and mix output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= ST_IDLE;
            r_voice     <= '0;
            r_cnt       <= '0;
            r_note      <= '{default: '0};
            r_addr      <= '{default: '0};
            r_prev_gate <= '0;
            r_done      <= '0;
            r_live      <= '0;
            r_active    <= '0;
            r_acc       <= '0;
            r_sample    <= '0;
            r_valid     <= 1'b0;
            r_dc        <= DC_RST;
            r_overrun   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (sample_tick && r_state != ST_IDLE) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        r_state     <= ST_SLOT;
                        r_voice     <= '0;
                        r_cnt       <= '0;
                        r_acc       <= '0;
                        r_prev_gate <= gate_in;
                        r_live      <= w_live_next;
                        r_active    <= w_live_next & w_note_ok;
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            r_note[v] <= w_note_in[v];
                            if (!gate_in[v] || !r_prev_gate[v]) begin
                                r_addr[v] <= '0;
                                r_done[v] <= 1'b0;
                            end
                        end
                    end
                end
                ST_SLOT: begin
                    if (r_cnt == LAST_CNT) begin
                        r_acc <= w_acc_next;
                        r_cnt <= '0;
                        if (r_live[r_voice]) begin
                            if (r_addr[r_voice] == LAST_ADDR) begin
                                r_addr[r_voice] <= '0;
                                if (LOOP == 0) begin
                                    r_done[r_voice] <= 1'b1;
                                end
                            end else begin
                                r_addr[r_voice] <= r_addr[r_voice] + ADDR_WIDTH'(1);
                            end
                        end
                        if (r_voice == LAST_VOICE) begin
                            r_state  <= ST_OUT;
                            r_sample <= w_sat;
                            r_dc     <= w_dc;
                            r_valid  <= 1'b1;
                        end else begin
                            r_voice <= r_voice + VOICE_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sample_out       = r_sample;
    assign sample_valid     = r_valid;
    assign dc_out           = r_dc;
    assign voice_active_out = r_active;
    assign busy_out         = (r_state != ST_IDLE);
    assign overrun_out      = r_overrun;

endmodule

// File: doc/poly_sample_voice_engine.md
Name: poly_sample_voice_engine

Overview:
Polyphonic successor to the single-note sample playback path. It holds NUM_VOICES independent voices, each with its own gate, note select and sample address counter. On every sample tick it time-multiplexes one shared sample BRAM (all notes concatenated, note index in the address MSBs) across the voices. It sums the signed samples, scales and saturates the sum, and produces one mixed sample per tick plus an offset-binary duty-cycle word for the pwm block.

Parameters:
NUM_VOICES, 4, number of simultaneous voices
NUM_NOTES, 8, number of note tables in the shared BRAM
NOTE_W, 3, note index width (clog2 NUM_NOTES)
BRAM_DEPTH, 8192, samples per note table
ADDR_WIDTH, 13, per-note sample address width
SAMPLE_W, 16, signed sample width (BRAM data and mix output)
READ_LATENCY, 2, BRAM clocks from address to valid data
LOOP, 1, 1 = wrap at end of table; 0 = one-shot, voice stops at end
MIX_SHIFT, 2, arithmetic right shift applied to the sum before saturation
DC_W, 8, width of pwm duty-cycle output

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  asynchronous, active-high reset
sample_tick  input  1  one-cycle frame-start strobe (16,384 Hz)
gate_in  input  NUM_VOICES  per-voice gate; bit v = voice v
note_in  input  NUM_VOICES*NOTE_W  per-voice note index; voice v at [v*NOTE_W +: NOTE_W]
mem_addr_out  output  NOTE_W+ADDR_WIDTH  shared BRAM read address {note, sample_addr}
mem_data_in  input  SAMPLE_W  signed BRAM read data
sample_out  output  SAMPLE_W  signed mixed sample, held between frames
sample_valid  output  1  one-cycle pulse when sample_out updates
dc_out  output  DC_W  sample_out[SAMPLE_W-1 -: DC_W] + 2^(DC_W-1), modulo 2^DC_W
voice_active_out  output  NUM_VOICES  voice is contributing this frame
busy_out  output  1  frame in progress
overrun_out  output  1  sticky: a tick arrived while busy

Behaviour:
- Reset (async) clears: all outputs to 0; dc_out to 2^(DC_W-1); all voice addresses, previous gates, done flags and the accumulator to 0; FSM to IDLE.
- FSM: IDLE -> (sample_tick) -> SLOT(v=0). SLOT issues the address, waits READ_LATENCY cycles, then accumulates and goes to the next v. After voice NUM_VOICES-1 -> OUT -> IDLE.
- Slot length is READ_LATENCY+1 cycles.
- sample_valid fires exactly NUM_VOICES*(READ_LATENCY+1)+1 cycles after the tick cycle (13 at defaults). busy_out is high from the cycle after the tick through the sample_valid cycle.
- On the tick cycle, gate_in and note_in are latched for the whole frame. Mid-frame changes are ignored.
- Per voice, per frame:
  - Gate low: contributes 0, address forced to 0, done cleared, active=0.
  - Rising gate (latched high, previous frame low): address restarts at 0 and sample 0 is read this frame.
  - Gate high and not done: reads {note, addr}, adds the sign-extended sample, then addr+1.
  - At addr = BRAM_DEPTH-1: if LOOP=1, next addr = 0. If LOOP=0, the voice sets done and contributes 0 from the next frame until a gate retrigger.
  - note index >= NUM_NOTES: contributes 0, address still advances, active=0.
- mem_addr_out is held constant for each full slot. It is 0 when idle and for inactive voices (no read required).
- Accumulator width is SAMPLE_W+clog2(NUM_VOICES), signed, cleared at frame start.
- OUT: result = acc >>> MIX_SHIFT, saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. Register sample_out and dc_out, and pulse sample_valid.
- sample_tick while busy: ignored (frame not restarted, addresses not advanced). overrun_out is set and held until reset.
- sample_tick on the OUT cycle counts as busy.
- voice_active_out updates at frame start and is held until the next frame.

Test Plan:
- Reset mid-frame (assert rst_in 5 cycles after a tick) -> all outputs 0 immediately, dc_out=0x80, busy_out=0; the next tick gives a clean frame.
- Voice 0 only, note 2, gate rising, BRAM model returning the address LSBs -> mem_addr_out=0x4000 in slot 0; sample_valid 13 cycles after the tick; over successive ticks, addresses 0x4000, 0x4001, 0x4002.
- All 4 voices gated, each reading 0x7FFF, MIX_SHIFT=0 -> sample_out=0x7FFF (saturated), dc_out=0xFF. All reading 0x8000 -> 0x8000, dc_out=0x00.
- Default MIX_SHIFT=2, voices returning 1000, -200, 300, 0 -> sample_out=275, dc_out=0x81.
- Address wrap: preload voice addr 8191. LOOP=1 -> next frame reads addr 0. LOOP=0 -> voice inactive and contributes 0 until the gate drops and rises again, which restarts at addr 0.
- Second tick 4 cycles after the first -> ignored, overrun_out=1 sticky, only one sample_valid; note_in changed mid-frame has no effect until the next frame.
